// File: rtl/spike_weight_fetch.sv
// -----------------------------------------------------------------------------
// spike_weight_fetch
//
// Turns spike events (source neuron IDs) into a stream of synaptic-weight
// words read from the PE's simple-dual-port weight BRAM. For each accepted
// spike the block reads WORDS_PER_SPIKE consecutive words starting at
// spike_id * WORDS_PER_SPIKE. It absorbs the BRAM's 1-cycle read latency and
// delivers the words, tagged with source ID and index, on a valid/ready
// stream.
//
// Reads are issued against a credit of 3. The credit counts words buffered
// plus the read in flight. Because the credit uses registered values only,
// there is no combinational path from w_ready to addrout. The 3-entry output
// buffer still sustains one word per cycle.
//
// Ports
//   clk          : single clock, rising edge
//   rst_n        : synchronous active-low reset
//   spike_valid  : spike event present
//   spike_id     : source neuron ID (IDW bits)
//   spike_ready  : spike accepted this cycle
//   addrout      : BRAM read address (AW bits)
//   bram_dout    : BRAM read data, valid one cycle after the address
//   w_valid      : weight word available
//   w_data       : weight word
//   w_idx        : word index within the spike
//   w_src        : spike ID the word belongs to
//   w_last       : final word of the spike
//   w_ready      : consumer accepts the word
//   busy         : a spike is fetching, a read is in flight, or words are buffered
// -----------------------------------------------------------------------------
module spike_weight_fetch #(
  parameter int  BRAM_WIDTH      = 32,
  parameter int  BRAM_DEPTH      = 256,
  parameter int  WORDS_PER_SPIKE = 4,
  localparam int AW              = $clog2(BRAM_DEPTH),
  localparam int WW              = $clog2(WORDS_PER_SPIKE),
  localparam int IDW             = AW - WW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spike_valid,
  input  logic [IDW-1:0]        spike_id,
  output logic                  spike_ready,
  output logic [AW-1:0]         addrout,
  input  logic [BRAM_WIDTH-1:0] bram_dout,
  output logic                  w_valid,
  output logic [BRAM_WIDTH-1:0] w_data,
  output logic [WW-1:0]         w_idx,
  output logic [IDW-1:0]        w_src,
  output logic                  w_last,
  input  logic                  w_ready,
  output logic                  busy
);

  typedef enum logic {IDLE, FETCH} state_e;

  localparam logic [WW-1:0] LAST_IDX = WW'(WORDS_PER_SPIKE - 1);

  // Fetch control state
  state_e          state_q;
  logic [IDW-1:0]  cur_id_q;
  logic [WW-1:0]   word_cnt_q;

  // Tag travelling alongside the single outstanding BRAM read
  logic            inflight_q;
  logic [IDW-1:0]  tag_id_q;
  logic [WW-1:0]   tag_idx_q;
  logic            tag_last_q;

  // 3-entry output FIFO
  logic [BRAM_WIDTH-1:0] buf_data_q [3];
  logic [WW-1:0]         buf_idx_q  [3];
  logic [IDW-1:0]        buf_src_q  [3];
  logic                  buf_last_q [3];
  logic [1:0]            wr_ptr_q;
  logic [1:0]            rd_ptr_q;
  logic [1:0]            occ_q;

  logic credit_ok;
  logic issue;
  logic last_issue;
  logic push;
  logic pop;

  // The credit is computed from registers only. A pop in the current cycle
  // frees a slot one cycle later. This is why the buffer is 3 deep and not 2:
  // the extra entry keeps 1 word/cycle flowing.
  assign credit_ok  = ({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3;
  assign issue      = (state_q == FETCH) && credit_ok;
  assign last_issue = issue && (word_cnt_q == LAST_IDX);

  // Spikes are taken when idle, or on the final read of the current spike so
  // that back-to-back spikes stream without a bubble.
  assign spike_ready = (state_q == IDLE) || last_issue;

  assign addrout = {cur_id_q, word_cnt_q};

  assign push    = inflight_q;
  assign w_valid = (occ_q != 2'd0);
  assign pop     = w_valid && w_ready;

  assign w_data = buf_data_q[rd_ptr_q];
  assign w_idx  = buf_idx_q[rd_ptr_q];
  assign w_src  = buf_src_q[rd_ptr_q];
  assign w_last = buf_last_q[rd_ptr_q];

  assign busy = (state_q == FETCH) || inflight_q || (occ_q != 2'd0);

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Fetch FSM and in-flight tag
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register in this block sees the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_id_q   <= '0;
      word_cnt_q <= '0;
      inflight_q <= 1'b0;
      tag_id_q   <= '0;
      tag_idx_q  <= '0;
      tag_last_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        tag_id_q   <= cur_id_q;
        tag_idx_q  <= word_cnt_q;
        tag_last_q <= last_issue;
        // Wraps to 0 after the last word, which matches the start of the next spike.
        word_cnt_q <= word_cnt_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (spike_valid) begin
            cur_id_q   <= spike_id;
            word_cnt_q <= '0;
            state_q    <= FETCH;
          end
        end
        FETCH: begin
          if (last_issue) begin
            if (spike_valid) begin
              cur_id_q   <= spike_id;
              word_cnt_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output buffer
  // NOTE: the storage is reset as well as the pointers. The head entry drives
  // w_* directly, so reset must leave zeros there. At three entries this costs
  // little.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      occ_q    <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        buf_data_q[i] <= '0;
        buf_idx_q[i]  <= '0;
        buf_src_q[i]  <= '0;
        buf_last_q[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        buf_data_q[wr_ptr_q] <= bram_dout;
        buf_idx_q[wr_ptr_q]  <= tag_idx_q;
        buf_src_q[wr_ptr_q]  <= tag_id_q;
        buf_last_q[wr_ptr_q] <= tag_last_q;
        wr_ptr_q             <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // The credit rule makes a push into a full buffer impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
                                  !(push && !pop && occ_q == 2'd3));

endmodule

// File: tb/tb_spike_weight_fetch.sv
// -----------------------------------------------------------------------------
// Testbench for spike_weight_fetch.
//
// Contains a behavioural BRAM (mem[] with a 1-cycle read register). The
// scoreboard expands every accepted spike into its expected words:
// {src, idx, last, mem[src*4+idx]}. Every word popped from the DUT is compared
// in order against the scoreboard. Directed steps also check exact cycle
// timing, address sequencing, backpressure and reset behaviour. A randomized
// phase then runs traffic against the same scoreboard.
// -----------------------------------------------------------------------------
module tb_spike_weight_fetch;

  localparam int BW  = 32;
  localparam int AW  = 8;
  localparam int WW  = 2;
  localparam int IDW = 6;

  logic           clk;
  logic           rst_n;
  logic           spike_valid;
  logic [IDW-1:0] spike_id;
  logic           spike_ready;
  logic [AW-1:0]  addrout;
  logic [BW-1:0]  bram_dout;
  logic           w_valid;
  logic [BW-1:0]  w_data;
  logic [WW-1:0]  w_idx;
  logic [IDW-1:0] w_src;
  logic           w_last;
  logic           w_ready;
  logic           busy;

  spike_weight_fetch #(
    .BRAM_WIDTH      (BW),
    .BRAM_DEPTH      (256),
    .WORDS_PER_SPIKE (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spike_valid (spike_valid),
    .spike_id    (spike_id),
    .spike_ready (spike_ready),
    .addrout     (addrout),
    .bram_dout   (bram_dout),
    .w_valid     (w_valid),
    .w_data      (w_data),
    .w_idx       (w_idx),
    .w_src       (w_src),
    .w_last      (w_last),
    .w_ready     (w_ready),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural BRAM with a 1-cycle read latency
  logic [BW-1:0] mem [256];
  always @(posedge clk) bram_dout <= mem[addrout];

  typedef struct packed {
    logic [IDW-1:0] src;
    logic [WW-1:0]  idx;
    logic           last;
    logic [BW-1:0]  data;
  } word_t;

  word_t exp_q[$];
  int    tests = 0;
  int    fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " spike_ready"}, spike_ready, 1);
    check({tag, " addrout"},     addrout,     0);
    check({tag, " w_valid"},     w_valid,     0);
    check({tag, " w_word"},      {w_src, w_idx, w_last, w_data}, 0);
    check({tag, " busy"},        busy,        0);
  endtask

  // Drains until the scoreboard is empty and the DUT is idle, with a bounded wait.
  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && (exp_q.size() != 0 || busy); i++) step();
    check({tag, " drained"}, {exp_q.size() == 0, busy}, {1'b1, 1'b0});
  endtask

  // Scoreboard monitor. It samples on the falling edge, when inputs are
  // stable for the coming rising edge.
  logic  hold_pending = 1'b0;
  word_t hold_word;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_pending = 1'b0;
    end else begin
      if (hold_pending)
        check("hold stable", {w_valid, w_src, w_idx, w_last, w_data}, {1'b1, hold_word});
      if (w_valid && w_ready) begin
        check("word expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0)
          check("word order", {w_src, w_idx, w_last, w_data}, exp_q.pop_front());
      end
      hold_pending = w_valid && !w_ready;
      hold_word    = {w_src, w_idx, w_last, w_data};
      if (spike_valid && spike_ready) begin
        for (int k = 0; k < 4; k++) begin
          word_t e;
          logic [AW-1:0] a;
          a      = {spike_id, k[WW-1:0]};
          e.src  = spike_id;
          e.idx  = k[WW-1:0];
          e.last = (k == 3);
          e.data = mem[a];
          exp_q.push_back(e);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = a;
    rst_n       = 1'b0;
    spike_valid = 1'b0;
    spike_id    = '0;
    w_ready     = 1'b1;
    step();
    step();
    check_reset_vals("reset");
    rst_n = 1'b1;

    // Single spike 5: 2-cycle latency, words 20..23, busy falls after the last pop
    spike_valid = 1'b1;
    spike_id    = 6'd5;
    check("t1 ready idle", spike_ready, 1);
    for (int k = 0; k <= 6; k++) begin
      step();
      if (k == 0) spike_valid = 1'b0;
      if (k <= 3) check("t1 addrout", addrout, 20 + k);
      check("t1 w_valid", w_valid, (k >= 2 && k <= 5));
      check("t1 busy", busy, (k <= 5));
      if (k == 2) check("t1 first word", {w_src, w_idx, w_last, w_data}, {6'd5, 2'd0, 1'b0, 32'd20});
      if (k == 5) check("t1 last word",  {w_src, w_idx, w_last, w_data}, {6'd5, 2'd3, 1'b1, 32'd23});
    end

    // Back-to-back spikes 1 and 2: 8 consecutive words 4..11
    spike_valid = 1'b1;
    spike_id    = 6'd1;
    for (int k = 0; k <= 10; k++) begin
      step();
      if (k == 0) spike_id = 6'd2;
      if (k <= 4) check("t2 spike_ready", spike_ready, (k == 3));
      if (k <= 4) check("t2 addrout", addrout, 4 + k);
      if (k == 4) spike_valid = 1'b0;
      check("t2 w_valid", w_valid, (k >= 2 && k <= 9));
      if (k >= 2 && k <= 9) check("t2 w_data", w_data, k + 2);
    end
    drain("t2", 20);

    // Spike 3 under full backpressure: 3 reads, address holds at 15
    w_ready     = 1'b0;
    spike_valid = 1'b1;
    spike_id    = 6'd3;
    for (int k = 0; k <= 6; k++) begin
      step();
      if (k == 0) spike_valid = 1'b0;
      check("t3 addrout", addrout, (k <= 2) ? 12 + k : 15);
      check("t3 w_valid", w_valid, (k >= 2));
    end
    check("t3 head", {w_src, w_idx, w_data}, {6'd3, 2'd0, 32'd12});
    check("t3 spike_ready", spike_ready, 0);
    check("t3 busy", busy, 1);
    w_ready = 1'b1;
    drain("t3", 20);

    // Spike 63: top of memory, no wrap
    spike_valid = 1'b1;
    spike_id    = 6'd63;
    for (int k = 0; k <= 3; k++) begin
      step();
      if (k == 0) spike_valid = 1'b0;
      check("t4 addrout", addrout, 252 + k);
    end
    drain("t4", 20);

    // Reset during spike 7 after two reads, then spike 0
    w_ready     = 1'b0;
    spike_valid = 1'b1;
    spike_id    = 6'd7;
    step();
    spike_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    check_reset_vals("t5 reset");
    rst_n   = 1'b1;
    w_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t5 quiet", {w_valid, busy}, 2'b00);
    end
    spike_valid = 1'b1;
    spike_id    = 6'd0;
    step();
    spike_valid = 1'b0;
    drain("t5", 20);

    // Randomized traffic with random memory contents
    for (int a = 0; a < 256; a++) mem[a] = $urandom;
    for (int c = 0; c < 2000; c++) begin
      step();
      spike_valid = ($urandom % 3) != 0;
      spike_id    = IDW'($urandom);
      w_ready     = ($urandom % 4) != 0;
    end
    spike_valid = 1'b0;
    w_ready     = 1'b1;
    drain("random", 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
